// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter: state encoding,
// block geometry and the block-word address helper.
package cache_fill_arbiter_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LAT     = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned WORD_W      = 3;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  // Base low bits are zero, so the word offset never carries out of the block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Issue/receive counter pair for one block fill. Both counters hold at zero
// while run is low and saturate at BLOCK_WORDS.
module cache_fill_arbiter_fill_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              recv_en,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [WORD_W-1:0] recv_word,
  output logic              issue_done,
  output logic              recv_last
);

  logic [CNT_W-1:0] issue_cnt_d, issue_cnt_q;
  logic [CNT_W-1:0] recv_cnt_d, recv_cnt_q;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (!run) begin
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_cnt_q != CNT_FULL) issue_cnt_d = issue_cnt_q + CNT_ONE;
      if (recv_en && recv_cnt_q != CNT_FULL) recv_cnt_d = recv_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign recv_word  = recv_cnt_q[WORD_W-1:0];
  assign issue_done = (issue_cnt_q == CNT_FULL);
  assign recv_last  = (recv_cnt_q == CNT_LAST);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates main memory between icache fills, dcache fills and dcache
// write-through stores; sequences 8-word block fills and steers returns.
//
// state | meaning
// IDLE  | sample requests, fixed priority d_wr > d_miss > i_miss
// FILL  | issue 8 pipelined reads, forward 8 returned words
// WRITE | single-cycle store to memory
// TURN  | dead cycle so the finished requester can drop its request
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              fill_valid,
  output logic              fill_sel_d,
  output logic [WORD_W-1:0] fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_done,
  output logic              busy
);

  state_e             state_d, state_q;
  logic               sel_d_d, sel_d_q;
  logic [ADDR_W-1:0]  base_d, base_q;
  logic [ADDR_W-1:0]  wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]  wr_data_d, wr_data_q;

  logic               in_fill;
  logic               word_rx;
  logic [CNT_W-1:0]   issue_cnt;
  logic [WORD_W-1:0]  recv_word;
  logic               issue_done;
  logic               recv_last;

  assign in_fill = (state_q == ST_FILL);
  assign word_rx = in_fill && mem_valid;

  cache_fill_arbiter_fill_counter u_fill_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (in_fill),
    .recv_en    (word_rx),
    .issue_cnt  (issue_cnt),
    .recv_word  (recv_word),
    .issue_done (issue_done),
    .recv_last  (recv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr)                 state_d = ST_WRITE;
        else if (d_miss || i_miss) state_d = ST_FILL;
      end
      ST_FILL:  if (word_rx && recv_last) state_d = ST_TURN;
      ST_WRITE: state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant context is captured only while arbitrating in IDLE.
  always_comb begin
    sel_d_d   = sel_d_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == ST_IDLE) begin
      if (d_wr) begin
        wr_addr_d = d_wr_addr;
        wr_data_d = d_wr_data;
      end else if (d_miss) begin
        sel_d_d = 1'b1;
        base_d  = d_miss_addr & BLOCK_MASK;
      end else if (i_miss) begin
        sel_d_d = 1'b0;
        base_d  = i_miss_addr & BLOCK_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_d_q   <= 1'b0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      sel_d_q   <= sel_d_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_valid  = 1'b0;
    fill_sel_d  = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_done   = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_FILL: begin
        if (!issue_done) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(base_q, issue_cnt);
        end
        if (mem_valid) begin
          fill_valid  = 1'b1;
          fill_sel_d  = sel_d_q;
          fill_word   = recv_word;
          fill_data   = mem_rdata;
          i_fill_done = recv_last && !sel_d_q;
          d_fill_done = recv_last && sel_d_q;
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = wr_data_q;
        d_wr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Arbitrates the single multi-cycle main memory between the instruction cache (block-fill reads), the data cache (block-fill reads) and data-cache write-through stores. It sits inside the unified memory subsystem between both caches and the memory bridge. It sequences each 8-word block fill as 8 back-to-back pipelined reads, steers returning words to the granted cache, and reports completion.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width
- BLOCK_WORDS, 8, words per cache block (16 bytes)
- MEM_LAT, 4, memory read latency in cycles (informational; returns are tracked via mem_valid)

Ports. Reset is rst: synchronous, active-high. The clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_miss  in  1  icache fill request, level, held until i_fill_done
- i_miss_addr  in  16  icache miss address
- d_miss  in  1  dcache fill request, level, held until d_fill_done
- d_miss_addr  in  16  dcache miss address
- d_wr  in  1  write-through store request, level, held until d_wr_done
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid (MEM_LAT cycles after a read issue)
- fill_valid  out  1  fill word valid this cycle
- fill_sel_d  out  1  fill target: 1 = dcache, 0 = icache
- fill_word  out  3  word offset within the block
- fill_data  out  16  fill word
- i_fill_done  out  1  one-cycle pulse: icache block complete
- d_fill_done  out  1  one-cycle pulse: dcache block complete
- d_wr_done  out  1  one-cycle pulse: store accepted
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL, WRITE, TURN.
- IDLE arbitration is fixed priority: d_wr > d_miss > i_miss. The grant is latched together with the block base (addr & 16'hFFF0), or the store addr/data for a write.
  - Grant to a store → WRITE.
  - Grant to a fill → FILL.
  - No request → stay in IDLE.
- FILL
  - The issue counter runs 0..7. While it is below 8: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - The receive counter increments on each mem_valid. Each returned word drives fill_valid=1, fill_word=recv_cnt, fill_data=mem_rdata, fill_sel_d=granted target.
  - On the 8th received word, pulse i_fill_done or d_fill_done in the same cycle, then go to TURN.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr/mem_wdata from the latched store; pulse d_wr_done; then go to TURN.
- TURN: one idle cycle so requesters can deassert; then go to IDLE. No request is sampled in TURN.
- A granted operation is never preempted. A request dropping mid-operation does not abort it.
- mem_valid is ignored in IDLE, WRITE and TURN. Stray returns, e.g. after a mid-fill reset, are discarded.
- The icache can be delayed by consecutive dcache traffic. This is accepted, because the dcache is finite per stalled instruction.

## Timing
- Reset: state=IDLE, all counters 0; every output 0 (mem_en, mem_wr, mem_addr, mem_wdata, fill_*, *_done, busy).
- Fill, with request first seen in IDLE at cycle T:
  - FILL from T+1; reads issued at T+1..T+8.
  - Words returned at T+5..T+12; done pulse at T+12.
  - TURN at T+13; IDLE at T+14.
  - Requester-to-done latency is 12 cycles.
- Store seen at T: WRITE at T+1 (mem write and d_wr_done); TURN at T+2; IDLE at T+3.
- Outputs are decoded from registered state and counters only, with no combinational input-to-output path, except the fill_data/fill_valid pass-through of mem_rdata/mem_valid.
- Counters are 4 bits (0..8), with no wrap. Address arithmetic is within the block: the base low 4 bits are zero, so no carry leaves the block.
- rst asserted in any state wins: the next cycle is IDLE with reset outputs and no done pulse.

## Structure
- A shared package holds the state encoding (IDLE, FILL, WRITE, TURN), BLOCK_WORDS, the block-offset mask and MEM_LAT.
- One natural sub-module is fill_counter: the issue/receive counter pair with the terminal-count flags issue_done and recv_last. The FSM stays in cache_fill_arbiter.

## Test plan
- icache fill only: i_miss=1, addr 0x1236 at T → mem reads 0x1230..0x123E at T+1..T+8; fill_word 0..7 with fill_sel_d=0 at T+5..T+12; i_fill_done at T+12; busy low at T+14.
- Simultaneous d_miss (0x4000) and i_miss (0x0100) → dcache block filled first, d_fill_done at T+12; icache reads begin at T+15 (i_miss still held).
- d_wr (0x2002, 0xBEEF) together with d_miss → WRITE at T+1 with mem_wr=1, addr 0x2002, data 0xBEEF, d_wr_done; d_miss granted at T+3.
- rst asserted at T+6 of a fill → T+7 all outputs 0 and IDLE; injected mem_valid at T+7..T+10 produces no fill_valid.
- Back-to-back i_miss kept high through TURN → no request sampled in TURN; second grant exactly at IDLE (T+14) with fresh addr.
